analog_ctrl_wb: RTL and testbench

Wishbone-slave control block for the user analog project: it turns management-SoC register writes into per-channel analog trim/enable controls and reports synchronised digital monitor inputs back as status and a maskable interrupt. It generalises the fixed single-project hookup into `NCH` channels of `CW`-bit controls. It adds a round-robin scan mode that time-multiplexes channel enables, and edge-triggered interrupts. It sits between the Caravel Wishbone/IRQ ports and the analog macro inside the user analog wrapper.

---
 rtl/analog_ctrl_wb.sv | 184 ++++++++++++++++++
 tb/tb_analog_ctrl_wb.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/analog_ctrl_wb.sv
// Wishbone register block for the user analog macro: per-channel trim/enable controls,
// round-robin scan of the channel enables, and edge-triggered monitor interrupts.
module analog_ctrl_wb #(
    parameter int          NCH      = 4,
    parameter int          CW       = 8,
    parameter int          NIN      = 8,
    parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic [NCH*CW-1:0] ctrl_o,
    output logic [NCH-1:0]    en_o,
    input  logic [NIN-1:0]    mon_i,
    output logic              irq_o
);
    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

    // Handshake: a selected cyc&stb is captured only while no transfer is in flight
    // (r_busy) or being acknowledged (r_ack). One edge after capture, ack pulses for a
    // single cycle, read data is presented with it, and a write commits on that edge.
    logic          r_busy;
    logic          r_we;
    logic [7:0]    r_off;
    logic [31:0]   r_dat;
    logic [3:0]    r_sel;
    logic          r_ack;
    logic [31:0]   r_rdata;

    logic [NCH-1:0] r_en;
    logic [NIN-1:0] r_pend;
    logic [NIN-1:0] r_mask;
    logic           r_mode;
    logic [15:0]    r_dwell;
    logic [PW-1:0]  r_ptr;
    logic [15:0]    r_dcnt;
    logic [CW-1:0]  r_ctrl [NCH];
    logic [NIN-1:0] r_s1, r_s2, r_s3;
    logic [NCH-1:0] r_en_o;
    logic           r_irq;

    logic           w_accept;
    logic           w_wr;
    logic [31:0]    w_wmask;
    logic [31:0]    w_rd;
    logic [31:0]    w_merged;
    logic [NCH-1:0] w_en_d;
    logic           w_mode_d;
    logic [PW-1:0]  w_ptr_d;
    logic [15:0]    w_dcnt_d;
    logic [NCH-1:0] w_onehot;
    logic [NCH-1:0] w_en_o_d;
    logic [NIN-1:0] w_clr;
    logic [NIN-1:0] w_rise;
    logic           w_unused;

    assign w_accept = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADR[31:8])
                      & ~r_busy & ~r_ack;
    assign w_wr     = r_busy & r_we;
    assign w_wmask  = {{8{r_sel[3]}}, {8{r_sel[2]}}, {8{r_sel[1]}}, {8{r_sel[0]}}};
    assign w_merged = (w_rd & ~w_wmask) | (r_dat & w_wmask);
    assign w_rise   = r_s2 & ~r_s3;
    assign w_unused = ^w_merged;

    always_comb begin
        w_rd = '0;
        case (r_off)
            8'h00: w_rd = {8'hA5, 8'(NCH), 8'(CW), 8'(NIN)};
            8'h04: w_rd[NCH-1:0] = r_en;
            8'h08: w_rd[NIN-1:0] = r_s2;
            8'h0C: w_rd[NIN-1:0] = r_pend;
            8'h10: w_rd[NIN-1:0] = r_mask;
            8'h14: begin
                w_rd[0]     = r_mode;
                w_rd[31:16] = r_dwell;
            end
            8'h18: w_rd[PW-1:0] = r_ptr;
            default: begin
                for (int k = 0; k < NCH; k++) begin
                    if (r_off == 8'(32 + 4 * k)) w_rd[CW-1:0] = r_ctrl[k];
                end
            end
        endcase
    end

    // Scan stepping uses the pre-write state; en_o is built from the post-edge values so
    // it always reflects the EN/MODE/ptr held in the same cycle.
    always_comb begin
        w_en_d   = r_en;
        w_mode_d = r_mode;
        w_clr    = '0;
        if (w_wr && r_off == 8'h04) w_en_d = w_merged[NCH-1:0];
        if (w_wr && r_off == 8'h14) w_mode_d = w_merged[0];
        if (w_wr && r_off == 8'h0C) w_clr = r_dat[NIN-1:0] & w_wmask[NIN-1:0];

        w_ptr_d  = r_ptr;
        w_dcnt_d = r_dcnt;
        if (!r_mode) begin
            w_ptr_d  = '0;
            w_dcnt_d = '0;
        end else if (!r_en[r_ptr] || r_dcnt == r_dwell) begin
            w_ptr_d  = (r_ptr == PW'(NCH - 1)) ? '0 : r_ptr + 1'b1;
            w_dcnt_d = '0;
        end else begin
            w_dcnt_d = r_dcnt + 16'd1;
        end

        w_onehot          = '0;
        w_onehot[w_ptr_d] = 1'b1;
        if (w_mode_d) w_en_o_d = w_en_d[w_ptr_d] ? w_onehot : '0;
        else          w_en_o_d = w_en_d;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_busy  <= 1'b0;
            r_we    <= 1'b0;
            r_off   <= '0;
            r_dat   <= '0;
            r_sel   <= '0;
            r_ack   <= 1'b0;
            r_rdata <= '0;
            r_en    <= '0;
            r_pend  <= '0;
            r_mask  <= '0;
            r_mode  <= 1'b0;
            r_dwell <= '0;
            r_ptr   <= '0;
            r_dcnt  <= '0;
            r_s1    <= '0;
            r_s2    <= '0;
            r_s3    <= '0;
            r_en_o  <= '0;
            r_irq   <= 1'b0;
            for (int k = 0; k < NCH; k++) r_ctrl[k] <= '0;
        end else begin
            if (w_accept) begin
                r_busy <= 1'b1;
                r_we   <= wbs_we_i;
                r_off  <= wbs_adr_i[7:0];
                r_dat  <= wbs_dat_i;
                r_sel  <= wbs_sel_i;
            end else begin
                r_busy <= 1'b0;
            end
            r_ack   <= r_busy;
            r_rdata <= (r_busy && !r_we) ? w_rd : '0;

            r_en   <= w_en_d;
            r_mode <= w_mode_d;
            r_ptr  <= w_ptr_d;
            r_dcnt <= w_dcnt_d;
            r_en_o <= w_en_o_d;
            if (w_wr && r_off == 8'h10) r_mask  <= w_merged[NIN-1:0];
            if (w_wr && r_off == 8'h14) r_dwell <= w_merged[31:16];
            for (int k = 0; k < NCH; k++) begin
                if (w_wr && r_off == 8'(32 + 4 * k)) r_ctrl[k] <= w_merged[CW-1:0];
            end

            r_s1   <= mon_i;
            r_s2   <= r_s1;
            r_s3   <= r_s2;
            // A new edge wins over a same-cycle clear.
            r_pend <= (r_pend & ~w_clr) | w_rise;
            r_irq  <= |(r_pend & r_mask);
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ctrl
        assign ctrl_o[k*CW +: CW] = r_ctrl[k];
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_rdata;
    assign en_o      = r_en_o;
    assign irq_o     = r_irq;
endmodule

// File: tb/tb_analog_ctrl_wb.sv
// Bench for analog_ctrl_wb: directed register/scan/interrupt/reset cases plus randomized
// bus traffic, all compared against a register-level model of the block.
module tb_analog_ctrl_wb;
    localparam int NCH = 4;
    localparam int CW  = 8;
    localparam int NIN = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cyc = 1'b0, stb = 1'b0, we_i = 1'b0;
    logic [3:0]        sel_i = '0;
    logic [31:0]       adr_i = '0, dat_i = '0;
    logic              ack;
    logic [31:0]       dat_o;
    logic [NCH*CW-1:0] ctrl_o;
    logic [NCH-1:0]    en_o;
    logic [NIN-1:0]    mon_i = '0;
    logic              irq;

    int checks = 0;
    int errors = 0;
    logic chk_on = 1'b0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    analog_ctrl_wb #(.NCH(NCH), .CW(CW), .NIN(NIN), .BASE_ADR(32'h3000_0000)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we_i),
        .wbs_sel_i(sel_i), .wbs_adr_i(adr_i), .wbs_dat_i(dat_i),
        .wbs_ack_o(ack), .wbs_dat_o(dat_o),
        .ctrl_o(ctrl_o), .en_o(en_o), .mon_i(mon_i), .irq_o(irq)
    );

    // Register-level model: architectural registers plus a monitor delay line.
    logic [3:0]  m_en;
    logic        m_mode;
    logic [15:0] m_dwell;
    int          m_ptr, m_dcnt;
    logic [7:0]  m_ctrl [NCH];
    logic [7:0]  m_pend, m_mask, m_s1, m_s2, m_s3;
    logic        m_irq, m_ack;
    logic        pv = 1'b0, p_we;
    logic [7:0]  p_off;
    logic [31:0] p_dat;
    logic [3:0]  p_sel;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] off);
        case (off)
            8'h00: return 32'hA504_0808;
            8'h04: return {28'h0, m_en};
            8'h08: return {24'h0, m_s2};
            8'h0C: return {24'h0, m_pend};
            8'h10: return {24'h0, m_mask};
            8'h14: return {m_dwell, 15'h0, m_mode};
            8'h18: return 32'(m_ptr);
            8'h20, 8'h24, 8'h28, 8'h2C: return {24'h0, m_ctrl[int'((off - 8'h20) >> 2)]};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [3:0] exp_en();
        logic [3:0] r;
        if (m_mode) begin
            r = '0;
            if (m_en[m_ptr]) r[m_ptr] = 1'b1;
        end else begin
            r = m_en;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_en = '0; m_mode = 1'b0; m_dwell = '0; m_ptr = 0; m_dcnt = 0;
        m_pend = '0; m_mask = '0; m_s1 = '0; m_s2 = '0; m_s3 = '0;
        m_irq = 1'b0; m_ack = 1'b0; pv = 1'b0;
        for (int k = 0; k < NCH; k++) m_ctrl[k] = '0;
    endtask

    task automatic model_step();
        logic [7:0]  rise, clr;
        logic [31:0] w, m;
        int          nptr, ndcnt;
        logic        nirq;
        rise = m_s2 & ~m_s3;
        nirq = |(m_pend & m_mask);
        nptr = m_ptr;
        ndcnt = m_dcnt;
        if (!m_mode) begin
            nptr = 0; ndcnt = 0;
        end else if (!m_en[m_ptr] || m_dcnt == int'(m_dwell)) begin
            nptr = (m_ptr + 1) % NCH; ndcnt = 0;
        end else begin
            ndcnt = m_dcnt + 1;
        end
        clr = '0;
        m_ack = pv;
        if (pv && p_we) begin
            w = lanes(model_read(p_off), p_dat, p_sel);
            m = lanes(32'h0, 32'hFFFF_FFFF, p_sel);
            case (p_off)
                8'h04: m_en = w[3:0];
                8'h0C: clr = p_dat[7:0] & m[7:0];
                8'h10: m_mask = w[7:0];
                8'h14: begin m_mode = w[0]; m_dwell = w[31:16]; end
                8'h20, 8'h24, 8'h28, 8'h2C: m_ctrl[int'((p_off - 8'h20) >> 2)] = w[7:0];
                default: ;
            endcase
        end
        pv = 1'b0;
        m_pend = (m_pend & ~clr) | rise;
        m_s3 = m_s2; m_s2 = m_s1; m_s1 = mon_i;
        m_ptr = nptr; m_dcnt = ndcnt; m_irq = nirq;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_step();
        end
    end

    // Every-cycle comparison of the free-running outputs against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("ack", {31'h0, ack}, {31'h0, m_ack});
            if (!ack) chk("dat_idle", dat_o, 32'h0);
            chk("en_o", {28'h0, en_o}, {28'h0, exp_en()});
            chk("ctrl_o", ctrl_o, {m_ctrl[3], m_ctrl[2], m_ctrl[1], m_ctrl[0]});
            chk("irq_o", {31'h0, irq}, {31'h0, m_irq});
        end
    end

    task automatic wb(input logic w, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, output logic [31:0] rd);
        logic hit;
        int   lat;
        hit = (adr[31:8] == 24'h30_0000);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we_i = w; adr_i = adr; dat_i = dat; sel_i = sel;
        @(posedge clk); #1;
        rd = '0;
        if (hit) begin
            p_we = w; p_off = adr[7:0]; p_dat = dat; p_sel = sel; pv = 1'b1;
            exp_q.push_back(w ? 32'h0 : model_read(adr[7:0]));
            lat = 0;
            do begin
                @(posedge clk); #1;
                lat++;
            end while (!ack && lat < 4);
            chk("ack_latency", 32'(lat), 32'd1);
            rd = dat_o;
            if (exp_q.size() > 0) chk("rd_data", dat_o, exp_q.pop_front());
        end else begin
            for (int i = 0; i < 8; i++) begin
                @(posedge clk); #1;
                chk("nosel_ack", {31'h0, ack}, 32'h0);
            end
        end
        cyc = 1'b0; stb = 1'b0; we_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [7:0]  offs [14];
        int          seq [17];
        offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18,
                 8'h20, 8'h24, 8'h28, 8'h2C, 8'h30, 8'h40, 8'h21};
        seq  = '{0, 2, 2, 2, 2, 0, 8, 8, 8, 8, 0, 2, 2, 2, 2, 0, 8};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_on = 1'b1;
        chk("rst_ack", {31'h0, ack}, 32'h0);
        chk("rst_dat", dat_o, 32'h0);
        chk("rst_ctrl", ctrl_o, 32'h0);
        chk("rst_en", {28'h0, en_o}, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);

        wb(1'b0, 32'h3000_0000, 32'h0, 4'hF, rd);
        chk("id_literal", rd, 32'hA504_0808);
        wb(1'b0, 32'h3000_0040, 32'h0, 4'hF, rd);
        chk("unmapped_literal", rd, 32'h0);
        wb(1'b0, 32'h3000_0100, 32'h0, 4'hF, rd);

        wb(1'b1, 32'h3000_0028, 32'h0000_00C3, 4'b0001, rd);
        chk("ctrl2_lane0", {24'h0, ctrl_o[23:16]}, 32'hC3);
        wb(1'b1, 32'h3000_0028, 32'h0000_FF00, 4'b0010, rd);
        chk("ctrl2_lane1", {24'h0, ctrl_o[23:16]}, 32'hC3);
        wb(1'b0, 32'h3000_0028, 32'h0, 4'hF, rd);
        chk("ctrl2_readback", rd, 32'hC3);

        wb(1'b1, 32'h3000_0004, 32'h0000_000A, 4'b0001, rd);
        chk("en_static", {28'h0, en_o}, 32'hA);
        wb(1'b1, 32'h3000_0014, 32'h0003_0001, 4'hF, rd);
        for (int i = 0; i < 17; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            chk("scan_seq", {28'h0, en_o}, 32'(seq[i]));
        end

        wb(1'b1, 32'h3000_0010, 32'h0000_0001, 4'hF, rd);
        mon_i[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("irq_latency", {31'h0, irq}, (i == 3) ? 32'h1 : 32'h0);
        end
        mon_i[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        wb(1'b1, 32'h3000_000C, 32'h0000_0001, 4'hF, rd);
        chk("irq_at_clear_ack", {31'h0, irq}, 32'h1);
        @(posedge clk); #1;
        chk("irq_after_clear", {31'h0, irq}, 32'h0);

        repeat (4) @(posedge clk);
        #1;
        mon_i[0] = 1'b1;
        wb(1'b1, 32'h3000_000C, 32'h0000_0001, 4'hF, rd);
        mon_i[0] = 1'b0;
        wb(1'b0, 32'h3000_000C, 32'h0, 4'hF, rd);
        chk("set_wins_pend", rd, 32'h1);
        wb(1'b1, 32'h3000_000C, 32'h0000_00FF, 4'hF, rd);

        for (int t = 0; t < 150; t++) begin
            logic [7:0]  off;
            logic [31:0] d;
            logic [31:0] base;
            off  = offs[$urandom_range(0, 13)];
            d    = $urandom;
            if (off == 8'h14) d[31:19] = '0;
            base = ($urandom_range(0, 19) == 0) ? 32'h3000_0100 : 32'h3000_0000;
            mon_i = 8'($urandom);
            wb(1'($urandom_range(0, 1)), base | {24'h0, off}, d, 4'($urandom_range(0, 15)), rd);
        end
        mon_i = '0;

        wb(1'b1, 32'h3000_0004, 32'h0000_000F, 4'hF, rd);
        wb(1'b1, 32'h3000_0014, 32'h0002_0001, 4'hF, rd);
        wb(1'b1, 32'h3000_0020, 32'h0000_005A, 4'hF, rd);
        repeat (5) @(posedge clk);
        #1;
        cyc = 1'b1; stb = 1'b1; we_i = 1'b1; adr_i = 32'h3000_0020;
        dat_i = 32'h55; sel_i = 4'hF;
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_ack", {31'h0, ack}, 32'h0);
        chk("rst_mid_en", {28'h0, en_o}, 32'h0);
        chk("rst_mid_ctrl", ctrl_o, 32'h0);
        cyc = 1'b0; stb = 1'b0; we_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        wb(1'b0, 32'h3000_0018, 32'h0, 4'hF, rd);
        chk("scanptr_after_rst", rd, 32'h0);

        repeat (3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
